// File: rtl/demux_dispatcher_pkg.sv
// Shared types and width helpers for the demux_dispatcher slice.
package demux_dispatcher_pkg;

  localparam int unsigned PAYLOAD_WIDTH = 8;

  typedef logic [PAYLOAD_WIDTH-1:0] payload_t;

  function automatic int unsigned dest_width(input int unsigned n_out);
    return (n_out > 1) ? $clog2(n_out) : 1;
  endfunction

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Single-producer/single-consumer FIFO of DEPTH entries with occupancy output.
module dispatch_fifo
  import demux_dispatcher_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = count_width(DEPTH),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_bits,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_bits,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  // Full is judged on count alone, so a same-cycle pop never frees a slot for the push.
  always_comb begin
    push_ready = (count_q != CNT_W'(DEPTH));
    pop_valid  = (count_q != '0);
    push       = push_valid && push_ready;
    pop        = pop_valid && pop_ready;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_bits;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign pop_bits = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/demux_dispatcher.sv
// Steers one decoupled input stream to N_OUT per-port FIFOs by destination index.
// Optional same-cycle pass-through when the target FIFO is empty: DEMUX_DISPATCHER_BYPASS_EN.
module demux_dispatcher
  import demux_dispatcher_pkg::*;
#(
  parameter  int unsigned N_OUT  = 4,
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned DEPTH  = 2,
  parameter  int unsigned DEST_W = dest_width(N_OUT),
  localparam int unsigned CNT_W  = count_width(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  output logic                   io_in_ready,
  input  logic                   io_in_valid,
  input  logic [WIDTH-1:0]       io_in_bits,
  input  logic [DEST_W-1:0]      io_in_dest,
  input  logic [N_OUT-1:0]       io_out_ready,
  output logic [N_OUT-1:0]       io_out_valid,
  output logic [N_OUT*WIDTH-1:0] io_out_bits,
  output logic                   io_drop,
  output logic [N_OUT*CNT_W-1:0] io_count
);

  logic [N_OUT-1:0] dest_hit, fifo_push, fifo_ready, fifo_valid, bypass;
  logic [WIDTH-1:0] fifo_bits [N_OUT];
  logic             dest_legal;
  logic             drop_d, drop_q;

  // An out-of-range dest matches no port; such beats are always accepted and discarded.
  always_comb begin
    dest_hit = '0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      dest_hit[k] = (io_in_dest == DEST_W'(k));
    end
    dest_legal  = |dest_hit;
    io_in_ready = !dest_legal || (|(dest_hit & fifo_ready));
    bypass      = '0;
`ifdef DEMUX_DISPATCHER_BYPASS_EN
    bypass = dest_hit & ~fifo_valid & io_out_ready;
`endif
    fifo_push    = {N_OUT{io_in_valid}} & dest_hit & ~bypass;
    drop_d       = io_in_valid && !dest_legal;
    io_out_valid = fifo_valid | ({N_OUT{io_in_valid}} & bypass);
    io_out_bits  = '0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      io_out_bits[k*WIDTH +: WIDTH] = bypass[k] ? io_in_bits : fifo_bits[k];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign io_drop = drop_q;

  for (genvar g = 0; g < N_OUT; g++) begin : g_port
    dispatch_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push_valid(fifo_push[g]),
      .push_ready(fifo_ready[g]),
      .push_bits (io_in_bits),
      .pop_valid (fifo_valid[g]),
      .pop_ready (io_out_ready[g]),
      .pop_bits  (fifo_bits[g]),
      .count     (io_count[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_demux_dispatcher.sv
// Self-checking bench for demux_dispatcher: queue-based model plus directed literal checks.
module tb_demux_dispatcher;
  import demux_dispatcher_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 2;
  localparam int unsigned DW = 2;
  localparam int unsigned CW = 2;

  logic           clock = 1'b0;
  logic           reset;
  logic           in_valid;
  logic [W-1:0]   in_bits;
  logic [DW-1:0]  in_dest;
  logic [N-1:0]   out_ready;
  logic           in_ready;
  logic [N-1:0]   out_valid;
  logic [N*W-1:0] out_bits;
  logic           drop;
  logic [N*CW-1:0] count;

  logic [2:0]     out_ready3;
  logic           in_ready3;
  logic [2:0]     out_valid3;
  logic [23:0]    out_bits3;
  logic           drop3;
  logic [5:0]     count3;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  demux_dispatcher #(.N_OUT(4), .WIDTH(8), .DEPTH(2)) u_dut (
    .clock(clock), .reset(reset),
    .io_in_ready(in_ready), .io_in_valid(in_valid), .io_in_bits(in_bits), .io_in_dest(in_dest),
    .io_out_ready(out_ready), .io_out_valid(out_valid), .io_out_bits(out_bits),
    .io_drop(drop), .io_count(count)
  );

  demux_dispatcher #(.N_OUT(3), .WIDTH(8), .DEPTH(2)) u_dut3 (
    .clock(clock), .reset(reset),
    .io_in_ready(in_ready3), .io_in_valid(in_valid), .io_in_bits(in_bits), .io_in_dest(in_dest),
    .io_out_ready(out_ready3), .io_out_valid(out_valid3), .io_out_bits(out_bits3),
    .io_drop(drop3), .io_count(count3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model for the 4-port instance: one queue per port.
  payload_t q [N][$];
  bit       primed = 0;
  int       accepted = 0;
  int       delivered = 0;

  always @(negedge clock) begin : model
    logic [N-1:0] ev, qv, byp;
    logic [W-1:0] eb [N];
    logic         er;
    ev  = '0;
    qv  = '0;
    byp = '0;
    for (int k = 0; k < N; k++) begin
      qv[k] = (q[k].size() != 0);
      ev[k] = qv[k];
      eb[k] = qv[k] ? q[k][0] : '0;
    end
    er = (q[in_dest].size() < D);
`ifdef DEMUX_DISPATCHER_BYPASS_EN
    if (in_valid && !qv[in_dest] && out_ready[in_dest]) begin
      byp[in_dest] = 1'b1;
      ev[in_dest]  = 1'b1;
      eb[in_dest]  = in_bits;
    end
`endif
    if (primed) begin
      check("in_ready", 32'(in_ready), 32'(er));
      check("out_valid", 32'(out_valid), 32'(ev));
      check("drop", 32'(drop), 32'd0);
      for (int k = 0; k < N; k++) begin
        if (ev[k]) check($sformatf("out_bits%0d", k), 32'(out_bits[k*W +: W]), 32'(eb[k]));
        check($sformatf("count%0d", k), 32'(count[k*CW +: CW]), q[k].size());
      end
    end
    if (reset) begin
      for (int k = 0; k < N; k++) q[k].delete();
      primed    = 1;
      accepted  = 0;
      delivered = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (qv[k] && out_ready[k]) begin
          void'(q[k].pop_front());
          delivered++;
        end
      end
      if (in_valid && er) begin
        accepted++;
        if (byp[in_dest]) delivered++;
        else q[in_dest].push_back(in_bits);
      end
    end
  end

  // Conservation counters for the 3-port instance, where dest 3 is illegal.
  int acc3_legal = 0, acc3_ill = 0, del3 = 0, drops3 = 0;

  always @(negedge clock) begin
    if (reset) begin
      acc3_legal = 0;
      acc3_ill   = 0;
      del3       = 0;
      drops3     = 0;
    end else begin
      if (in_valid && in_ready3) begin
        if (in_dest == 2'd3) acc3_ill++;
        else acc3_legal++;
      end
      for (int k = 0; k < 3; k++) if (out_valid3[k] && out_ready3[k]) del3++;
      if (drop3) drops3++;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  sent;
    int  cyc;
    bit  acc;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_bits    = '0;
    in_dest    = '0;
    out_ready  = '1;
    out_ready3 = '1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);

    // Single beat to port 2.
    step(); in_valid = 1'b1; in_bits = 8'hA1; in_dest = 2'd2;
    @(negedge clock);
`ifdef DEMUX_DISPATCHER_BYPASS_EN
    check("a1_same_valid", 32'(out_valid), 32'h4);
    check("a1_same_bits", 32'(out_bits[23:16]), 32'hA1);
    check("a1_same_count", 32'(count), 32'd0);
`else
    check("a1_same_valid", 32'(out_valid), 32'h0);
`endif
    step(); in_valid = 1'b0;
    @(negedge clock);
`ifdef DEMUX_DISPATCHER_BYPASS_EN
    check("a1_next_valid", 32'(out_valid), 32'h0);
`else
    check("a1_next_valid", 32'(out_valid), 32'h4);
    check("a1_next_bits", 32'(out_bits[23:16]), 32'hA1);
`endif

    // Port 0 stalled: fill it, third beat refused, port 3 still flows.
    step(); out_ready = 4'b1110; in_valid = 1'b1; in_dest = 2'd0; in_bits = 8'h10;
    @(negedge clock); check("p0_b0_ready", 32'(in_ready), 32'd1);
    step(); in_bits = 8'h11;
    @(negedge clock); check("p0_b1_ready", 32'(in_ready), 32'd1);
    step(); in_bits = 8'h12;
    @(negedge clock);
    check("p0_full_ready", 32'(in_ready), 32'd0);
    check("p0_full_count", 32'(count[1:0]), 32'd2);
    check("p0_head", 32'(out_bits[7:0]), 32'h10);
    step(); in_valid = 1'b0;
    step(); in_valid = 1'b1; in_dest = 2'd3; in_bits = 8'h30;
    @(negedge clock); check("p3_ready", 32'(in_ready), 32'd1);
    step(); in_dest = 2'd0; in_bits = 8'h12; out_ready = '1;
    @(negedge clock);
    check("p0_pop_push_ready", 32'(in_ready), 32'd0);
    check("p0_pop_bits", 32'(out_bits[7:0]), 32'h10);
    step();
    @(negedge clock);
    check("p0_retry_ready", 32'(in_ready), 32'd1);
    check("p0_second", 32'(out_bits[7:0]), 32'h11);
    check("p0_retry_count", 32'(count[1:0]), 32'd1);
    step(); in_valid = 1'b0;
    @(negedge clock); check("p0_third", 32'(out_bits[7:0]), 32'h12);
    step();
    @(negedge clock); check("p0_empty", 32'(out_valid[0]), 32'd0);

    // Port 1 full: simultaneous pop and push, push refused.
    step(); out_ready = 4'b1101; in_valid = 1'b1; in_dest = 2'd1; in_bits = 8'h21;
    step(); in_bits = 8'h22;
    step(); out_ready = '1; in_bits = 8'h23;
    @(negedge clock);
    check("p1_full_ready", 32'(in_ready), 32'd0);
    check("p1_full_count", 32'(count[3:2]), 32'd2);
    step();
    @(negedge clock);
    check("p1_after_count", 32'(count[3:2]), 32'd1);
    check("p1_after_ready", 32'(in_ready), 32'd1);
    step(); in_valid = 1'b0;
    @(negedge clock);
    check("p1_keep_count", 32'(count[3:2]), 32'd1);
    check("p1_keep_bits", 32'(out_bits[15:8]), 32'h23);
    step();

    // Mid-stream reset with two beats queued on port 1.
    step(); out_ready = 4'b1101; in_valid = 1'b1; in_dest = 2'd1; in_bits = 8'h51;
    step(); in_bits = 8'h52;
    step(); in_valid = 1'b0;
    @(negedge clock); check("mid_count_pre", 32'(count[3:2]), 32'd2);
    step(); reset = 1'b1;
    step(); reset = 1'b0; out_ready = '1;
    @(negedge clock);
    check("mid_valid1", 32'(out_valid[1]), 32'd0);
    check("mid_count", 32'(count), 32'd0);
    check("mid_ready", 32'(in_ready), 32'd1);

    // Illegal destination on the 3-port instance.
    step(); in_valid = 1'b1; in_dest = 2'd3; in_bits = 8'hEE;
    @(negedge clock);
    check("ill_ready3", 32'(in_ready3), 32'd1);
    check("ill_drop_pre", 32'(drop3), 32'd0);
    step(); in_valid = 1'b0;
    @(negedge clock);
    check("ill_drop", 32'(drop3), 32'd1);
    check("ill_valid3", 32'(out_valid3), 32'd0);
    check("ill_count3", 32'(count3), 32'd0);
    step();
    @(negedge clock); check("ill_drop_end", 32'(drop3), 32'd0);

    // Random traffic; a held beat stays stable until the 4-port instance takes it.
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 60000) begin
      @(negedge clock);
      acc = in_valid && in_ready;
      @(posedge clock);
      #1;
      cyc++;
      if (acc) sent++;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_bits  = W'($urandom);
        in_dest  = DW'($urandom_range(0, 3));
      end
      for (int k = 0; k < N; k++) out_ready[k] = ($urandom_range(0, 3) != 0);
      out_ready3 = 3'($urandom);
    end
    check("rand_sent", sent, 10000);
    in_valid   = 1'b0;
    out_ready  = '1;
    out_ready3 = '1;
    repeat (3) @(negedge clock);
    for (int i = 0; i < 20 && (out_valid != 0 || out_valid3 != 0); i++) @(negedge clock);
    step();
    check("flush_count", 32'(count), 32'd0);
    check("flush_count3", 32'(count3), 32'd0);
    check("conserve", accepted, delivered);
    check("conserve3", acc3_legal, del3);
    check("drops3", drops3, acc3_ill);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
